reg_file: RTL and testbench

Integer register file for the ARMv8 single-cycle datapath: 32 entries of 64 bits, two asynchronous read ports, and one synchronous write port. It consumes the read addresses produced by the decode stage: read port 1 takes `Rn`, and read port 2 takes the `Rm`/`Rt` selection made under `reg2loc`. Index 31 is the zero register (XZR). Write-back data is bypassed to the read ports in the same cycle it is written.

---
 rtl/armv8_pkg.sv | 13 +
 rtl/reg_file.sv | 85 ++++++++
 tb/tb_reg_file.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/armv8_pkg.sv
// armv8_pkg
//   Shared architectural constants and types for the ARMv8 single-cycle
//   datapath: register width, register index width, and the XZR index.
package armv8_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int XZR_IDX    = 31;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xword_t;

endpackage : armv8_pkg

// File: rtl/reg_file.sv
// reg_file
//   Integer register file: 2^ADDR_W entries of DATA_W bits, two combinational
//   read ports with write-first bypass, one synchronous write port. Entry
//   ZERO_IDX (XZR) always reads as zero and silently discards writes.
//
// Ports
//   clk        : write clock (rising edge)
//   reset      : asynchronous active-high clear of every entry
//   read_reg1  : read port 1 index (Rn)
//   read_reg2  : read port 2 index (Rm or Rt, selected upstream by reg2loc)
//   write_reg  : write index (Rd/Rt)
//   write_data : write-back value
//   reg_write  : write enable
//   read_data1 : data selected by read_reg1
//   read_data2 : data selected by read_reg2
module reg_file
  import armv8_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int ZERO_IDX = XZR_IDX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs_q [NREGS];

  // One flop bank per entry; the XZR entry is held at zero permanently so
  // no write can ever land in it.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_entry
      if (gi == ZERO_IDX) begin : g_zero
        always_ff @(posedge clk or posedge reset) begin
          regs_q[gi] <= '0;
        end
      end else begin : g_rw
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            regs_q[gi] <= '0;
          end else if (reg_write && (write_reg == ADDR_W'(gi))) begin
            regs_q[gi] <= write_data;
          end
        end
      end
    end
  endgenerate

  // Read port 1. XZR check comes first so the bypass can never leak a value
  // being written to index 31; reset masks the bypass so outputs read zero.
  always_comb begin
    read_data1 = '0;
    if (!reset && (read_reg1 != ZERO_SEL)) begin
      if (reg_write && (write_reg == read_reg1)) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs_q[read_reg1];
      end
    end
  end

  // Read port 2, identical structure to port 1.
  always_comb begin
    read_data2 = '0;
    if (!reset && (read_reg2 != ZERO_SEL)) begin
      if (reg_write && (write_reg == read_reg2)) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs_q[read_reg2];
      end
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Directed bench for reg_file with a behavioural register model checked on
//   every falling edge, plus literal expectations at the key scenarios.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] read_data1;
  logic [63:0] read_data2;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit mon_en    = 0;

  logic [63:0] model [32];

  reg_file dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: what the register contents must be.
  always @(posedge reset) begin
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (reg_write && write_reg != 5'd31) begin
      model[write_reg] = write_data;
    end
  end

  // Value a read port must show right now.
  function automatic logic [63:0] expect_read(input logic [4:0] idx);
    if (reset)                             return 64'h0;
    if (idx == 5'd31)                      return 64'h0;
    if (reg_write && write_reg == idx)     return write_data;
    return model[idx];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_rd1", read_data1, expect_read(read_reg1));
      chk("mon_rd2", read_data2, expect_read(read_reg2));
      $display("cyc rr1=%0d rr2=%0d wr=%0d we=%0b wd=%h rd1=%h rd2=%h",
               read_reg1, read_reg2, write_reg, reg_write, write_data,
               read_data1, read_data2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [63:0] val);
    write_reg = idx; write_data = val; reg_write = 1'b1;
    cyc();
    reg_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    reset = 1'b1; read_reg1 = 5'd0; read_reg2 = 5'd0;
    write_reg = 5'd0; write_data = 64'h0; reg_write = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    mon_en = 1'b1;

    // Reset pulse between edges clears a written entry immediately.
    wr(5'd3, 64'h77);
    read_reg1 = 5'd3; read_reg2 = 5'd9;
    #2;
    chk("pre_reset_x3", read_data1, 64'h77);
    reset = 1'b1;
    #1;
    chk("reset_rd1", read_data1, 64'h0);
    chk("reset_rd2", read_data2, 64'h0);
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 31; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(30 - i);
      #2;
      chk("post_reset_rd1", read_data1, 64'h0);
      chk("post_reset_rd2", read_data2, 64'h0);
      cyc();
    end

    // Write then read.
    wr(5'd5, 64'h0000_0000_DEAD_BEEF);
    read_reg1 = 5'd5; read_reg2 = 5'd6;
    #2;
    chk("wr_x5", read_data1, 64'h0000_0000_DEAD_BEEF);
    chk("wr_x6_zero", read_data2, 64'h0);
    cyc();

    // XZR: write discarded, no bypass.
    read_reg1 = 5'd31; read_reg2 = 5'd31;
    write_reg = 5'd31; write_data = 64'hFFFF_FFFF_FFFF_FFFF; reg_write = 1'b1;
    #2;
    chk("xzr_bypass_rd1", read_data1, 64'h0);
    chk("xzr_bypass_rd2", read_data2, 64'h0);
    cyc();
    reg_write = 1'b0;
    #2;
    chk("xzr_later_rd1", read_data1, 64'h0);
    chk("xzr_later_rd2", read_data2, 64'h0);
    cyc();

    // Bypass: disabled shows old X6, enabled shows write_data pre-edge.
    wr(5'd6, 64'h99);
    read_reg1 = 5'd6; read_reg2 = 5'd6;
    write_reg = 5'd6; write_data = 64'h1234; reg_write = 1'b0;
    #2;
    chk("nobypass_rd2", read_data2, 64'h99);
    reg_write = 1'b1;
    #1;
    chk("bypass_rd2", read_data2, 64'h1234);
    chk("bypass_rd1", read_data1, 64'h1234);
    cyc();
    reg_write = 1'b0;
    #2;
    chk("bypass_committed", read_data2, 64'h1234);
    cyc();

    // reg2loc pairing: port 2 follows its index with zero latency.
    wr(5'd5, 64'hA);
    wr(5'd6, 64'hB);
    read_reg2 = 5'd5;
    #1;
    chk("reg2loc_rm", read_data2, 64'hA);
    read_reg2 = 5'd6;
    #1;
    chk("reg2loc_rt", read_data2, 64'hB);
    cyc();

    // Reset coincident with a write loses the write.
    write_reg = 5'd7; write_data = 64'h55; reg_write = 1'b1;
    read_reg1 = 5'd7; read_reg2 = 5'd0;
    @(posedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0; reg_write = 1'b0;
    #2;
    chk("rst_write_lost", read_data1, 64'h0);
    cyc();
    wr(5'd7, 64'h55);
    #2;
    chk("rst_then_write", read_data1, 64'h55);
    cyc();

    // Pseudo-random traffic checked by the model only.
    for (int i = 0; i < 60; i++) begin
      read_reg1  = 5'($urandom_range(0, 31));
      read_reg2  = (i % 4 == 0) ? read_reg1 : 5'($urandom_range(0, 31));
      write_reg  = (i % 3 == 0) ? read_reg2 : 5'($urandom_range(0, 31));
      write_data = {$urandom, $urandom};
      reg_write  = 1'($urandom_range(0, 1));
      cyc();
    end
    reg_write = 1'b0;
    cyc();
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_reg_file
